// File: rtl/nc_context_store_if.sv
// Bus between the CAVLC residual decoder / MB sequencer and the nC context store.
// The master drives MB sequencing and TotalCoeff writes. The slave returns the packed nC context.
interface nc_context_store_if #(
    parameter int unsigned MB_X_BITS = 7,
    parameter int unsigned MB_Y_BITS = 7
);
    logic                 slice_start_in;
    logic [MB_X_BITS-1:0] mb_x_in;
    logic [MB_Y_BITS-1:0] mb_y_in;
    logic                 mb_start_in;
    logic                 mb_end_in;
    logic                 wr_en_in;
    logic [1:0]           wr_comp_in;
    logic [3:0]           wr_blk_idx_in;
    logic [4:0]           total_coeff_in;
    logic                 ready_out;
    logic                 seq_err_out;
    logic [31:0]          nC_up_mb_out;
    logic [31:0]          nC_left_mb_out;
    logic [127:0]         nC_curr_mb_out;
    logic [15:0]          nC_cb_up_mb_out;
    logic [15:0]          nC_cr_up_mb_out;
    logic [15:0]          nC_cb_left_mb_out;
    logic [15:0]          nC_cr_left_mb_out;
    logic [31:0]          nC_cb_curr_mb_out;
    logic [31:0]          nC_cr_curr_mb_out;

    modport master (
        output slice_start_in, mb_x_in, mb_y_in, mb_start_in, mb_end_in,
               wr_en_in, wr_comp_in, wr_blk_idx_in, total_coeff_in,
        input  ready_out, seq_err_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
               nC_cb_up_mb_out, nC_cr_up_mb_out, nC_cb_left_mb_out, nC_cr_left_mb_out,
               nC_cb_curr_mb_out, nC_cr_curr_mb_out
    );

    modport slave (
        input  slice_start_in, mb_x_in, mb_y_in, mb_start_in, mb_end_in,
               wr_en_in, wr_comp_in, wr_blk_idx_in, total_coeff_in,
        output ready_out, seq_err_out, nC_up_mb_out, nC_left_mb_out, nC_curr_mb_out,
               nC_cb_up_mb_out, nC_cr_up_mb_out, nC_cb_left_mb_out, nC_cr_left_mb_out,
               nC_cb_curr_mb_out, nC_cr_curr_mb_out
    );
endinterface

// File: rtl/nc_context_store.sv
// TotalCoeff context store (current, left and above MB) feeding the nC predictor.
// Optional NC_WRITE_FWD_EN: forward an accepted write onto the current outputs in the same cycle.
module nc_context_store #(
    parameter int unsigned MB_X_BITS = 7,
    parameter int unsigned MB_Y_BITS = 7
) (
    input logic               clk,
    input logic               rst_n,
    nc_context_store_if.slave bus
);
    localparam int unsigned Depth = 1 << MB_X_BITS;

    typedef enum logic [1:0] {StIdle, StLoad, StReady, StCommit} stateT;

    stateT                stateQ, stateD;
    logic [MB_X_BITS-1:0] mbXQ, mbXD;
    logic [MB_Y_BITS-1:0] mbYQ, mbYD;
    logic                 seqErrQ, seqErrD;
    logic [127:0]         currLumaQ, currLumaW, currLumaD;
    logic [31:0]          currCbQ, currCbW, currCbD, currCrQ, currCrW, currCrD;
    logic [31:0]          upLumaQ, upLumaD, leftLumaOutQ, leftLumaOutD, leftLumaQ, leftLumaD;
    logic [15:0]          upCbQ, upCbD, upCrQ, upCrD;
    logic [15:0]          leftCbOutQ, leftCbOutD, leftCrOutQ, leftCrOutD;
    logic [15:0]          leftCbQ, leftCbD, leftCrQ, leftCrD;
    logic [63:0]          lineMem [Depth];
    logic [63:0]          rdDataQ, memWData;
    logic                 memWe, startMb, wrAccept;
    logic [7:0]           wrByte;

    // Write is dropped when the same cycle restarts the MB without committing it.
    assign wrAccept = (stateQ == StReady) && bus.wr_en_in && !bus.slice_start_in &&
                      !(bus.mb_start_in && !bus.mb_end_in);
    assign startMb  = !bus.slice_start_in && bus.mb_start_in &&
                      ((stateQ == StIdle) || ((stateQ == StReady) && !bus.mb_end_in));
    assign wrByte   = {3'b000, (bus.total_coeff_in > 5'd16) ? 5'd16 : bus.total_coeff_in};

    // Bottom row of the current MB: luma 10,11,14,15, cb 2,3, cr 2,3.
    assign memWData = {currLumaQ[127:112], currLumaQ[95:80], currCbQ[31:16], currCrQ[31:16]};

    always_comb begin
        currLumaW = currLumaQ;
        currCbW   = currCbQ;
        currCrW   = currCrQ;
        if (wrAccept) begin
            case (bus.wr_comp_in)
                2'd0:    currLumaW[{bus.wr_blk_idx_in, 3'b000} +: 8] = wrByte;
                2'd1:    currCbW[{bus.wr_blk_idx_in[1:0], 3'b000} +: 8] = wrByte;
                2'd2:    currCrW[{bus.wr_blk_idx_in[1:0], 3'b000} +: 8] = wrByte;
                default: ;
            endcase
        end
        currLumaD = startMb ? '0 : currLumaW;
        currCbD   = startMb ? '0 : currCbW;
        currCrD   = startMb ? '0 : currCrW;
    end

    always_comb begin
        stateD       = stateQ;
        seqErrD      = seqErrQ;
        mbXD         = mbXQ;
        mbYD         = mbYQ;
        upLumaD      = upLumaQ;
        upCbD        = upCbQ;
        upCrD        = upCrQ;
        leftLumaOutD = leftLumaOutQ;
        leftCbOutD   = leftCbOutQ;
        leftCrOutD   = leftCrOutQ;
        leftLumaD    = leftLumaQ;
        leftCbD      = leftCbQ;
        leftCrD      = leftCrQ;
        memWe        = 1'b0;
        if (bus.slice_start_in) begin
            stateD    = StIdle;
            seqErrD   = 1'b0;
            leftLumaD = '0;
            leftCbD   = '0;
            leftCrD   = '0;
        end else begin
            if ((bus.wr_en_in || bus.mb_end_in) && stateQ != StReady) seqErrD = 1'b1;
            if (bus.mb_start_in && stateQ != StIdle) seqErrD = 1'b1;
            unique case (stateQ)
                StIdle: ;
                StLoad: begin
                    stateD       = StReady;
                    upLumaD      = (mbYQ == '0) ? '0 : rdDataQ[63:32];
                    upCbD        = (mbYQ == '0) ? '0 : rdDataQ[31:16];
                    upCrD        = (mbYQ == '0) ? '0 : rdDataQ[15:0];
                    leftLumaOutD = (mbXQ == '0) ? '0 : leftLumaQ;
                    leftCbOutD   = (mbXQ == '0) ? '0 : leftCbQ;
                    leftCrOutD   = (mbXQ == '0) ? '0 : leftCrQ;
                end
                StReady: if (bus.mb_end_in) stateD = StCommit;
                StCommit: begin
                    stateD    = StIdle;
                    memWe     = 1'b1;
                    // Right column: luma 5,7,13,15 and chroma 1,3.
                    leftLumaD = {currLumaQ[127:120], currLumaQ[111:104],
                                 currLumaQ[63:56], currLumaQ[47:40]};
                    leftCbD   = {currCbQ[31:24], currCbQ[15:8]};
                    leftCrD   = {currCrQ[31:24], currCrQ[15:8]};
                end
            endcase
            if (startMb) begin
                stateD = StLoad;
                mbXD   = bus.mb_x_in;
                mbYD   = bus.mb_y_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ       <= StIdle;
            seqErrQ      <= 1'b0;
            mbXQ         <= '0;
            mbYQ         <= '0;
            currLumaQ    <= '0;
            currCbQ      <= '0;
            currCrQ      <= '0;
            upLumaQ      <= '0;
            upCbQ        <= '0;
            upCrQ        <= '0;
            leftLumaOutQ <= '0;
            leftCbOutQ   <= '0;
            leftCrOutQ   <= '0;
            leftLumaQ    <= '0;
            leftCbQ      <= '0;
            leftCrQ      <= '0;
        end else begin
            stateQ       <= stateD;
            seqErrQ      <= seqErrD;
            mbXQ         <= mbXD;
            mbYQ         <= mbYD;
            currLumaQ    <= currLumaD;
            currCbQ      <= currCbD;
            currCrQ      <= currCrD;
            upLumaQ      <= upLumaD;
            upCbQ        <= upCbD;
            upCrQ        <= upCrD;
            leftLumaOutQ <= leftLumaOutD;
            leftCbOutQ   <= leftCbOutD;
            leftCrOutQ   <= leftCrOutD;
            leftLumaQ    <= leftLumaD;
            leftCbQ      <= leftCbD;
            leftCrQ      <= leftCrD;
        end
    end

    always_ff @(posedge clk) begin
        if (memWe && !bus.slice_start_in) lineMem[mbXQ] <= memWData;
        if (startMb) rdDataQ <= lineMem[bus.mb_x_in];
    end

    assign bus.ready_out         = (stateQ == StReady);
    assign bus.seq_err_out       = seqErrQ;
    assign bus.nC_up_mb_out      = upLumaQ;
    assign bus.nC_cb_up_mb_out   = upCbQ;
    assign bus.nC_cr_up_mb_out   = upCrQ;
    assign bus.nC_left_mb_out    = leftLumaOutQ;
    assign bus.nC_cb_left_mb_out = leftCbOutQ;
    assign bus.nC_cr_left_mb_out = leftCrOutQ;
`ifdef NC_WRITE_FWD_EN
    assign bus.nC_curr_mb_out    = currLumaW;
    assign bus.nC_cb_curr_mb_out = currCbW;
    assign bus.nC_cr_curr_mb_out = currCrW;
`else
    assign bus.nC_curr_mb_out    = currLumaQ;
    assign bus.nC_cb_curr_mb_out = currCbQ;
    assign bus.nC_cr_curr_mb_out = currCrQ;
`endif
endmodule
